// File: rtl/mm_pkg.sv
// Shared types and sizes for the matrix-multiply feed/drain controller.
// Holds the controller state enum, array geometry, the load payload layout
// and the drain-index to array-select mapping.
package mm_pkg;

  localparam int unsigned N        = 4;   // array is N x N
  localparam int unsigned FEED_LEN = 4;   // operand feed beats (one per k)
  localparam int unsigned DW       = 8;   // operand byte width
  localparam int unsigned RW       = 32;  // result / row width
  localparam int unsigned IW       = 2;   // row/column index width

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    FLUSH = 3'd3,
    DRAIN = 3'd4
  } state_e;

  // One operand row write: sel=0 targets A, sel=1 targets B.
  typedef struct packed {
    logic          sel;
    logic [IW-1:0] idx;
    logic [RW-1:0] data;
  } load_req_t;

  // Result index is row-major (4r+c); the array select is column-major (4c+r).
  function automatic logic [2*IW-1:0] arr_sel_of(input logic [2*IW-1:0] idx);
    return {idx[IW-1:0], idx[2*IW-1:IW]};
  endfunction

endpackage

// File: rtl/mm_opnd_buf.sv
// 4x4 byte operand register file: one row write per cycle, N independent
// element read ports.
//   clk, rst_n      : clock, async active-low reset (clears all bytes)
//   wr_en/wr_row    : write strobe and row index
//   wr_data         : row payload, byte k lands in column k
//   rd_row/rd_col   : per-port element address
//   rd_data         : per-port element value
module mm_opnd_buf
  import mm_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [IW-1:0]          wr_row,
  input  logic [RW-1:0]          wr_data,
  input  logic [N-1:0][IW-1:0]   rd_row,
  input  logic [N-1:0][IW-1:0]   rd_col,
  output logic [N-1:0][DW-1:0]   rd_data
);

  logic [N-1:0][N-1:0][DW-1:0] mem_q;

  // Row storage; a packed row is exactly the write payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (wr_en) begin
      mem_q[wr_row] <= wr_data;
    end
  end

  // Element read ports.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      rd_data[i] = mem_q[rd_row[i]][rd_col[i]];
    end
  end

endmodule

// File: rtl/mm_feed_drain_ctrl.sv
// Feed/drain controller for a 4x4 PE array computing C = A*B.
// Buffers A and B rows, clears the array, feeds one k-slice per cycle,
// flushes with zeros, then streams the 16 results out row-major.
//   clk, rst_n                 : clock, async active-low reset
//   load_valid/ready/sel/idx/data : operand row write (sel 0=A, 1=B)
//   start, busy, done          : job control
//   arr_rst_n, arr_en          : array reset (gated by rst_n) and enable
//   data_out0..3, weight_out0..3 : A column k / B row k to the array
//   arr_out_sel, arr_result    : array result select and returned value
//   res_valid/ready/data/idx/last : result stream
module mm_feed_drain_ctrl
  import mm_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic              load_sel,
  input  logic [IW-1:0]     load_idx,
  input  logic [RW-1:0]     load_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              arr_rst_n,
  output logic              arr_en,
  output logic [DW-1:0]     data_out0,
  output logic [DW-1:0]     data_out1,
  output logic [DW-1:0]     data_out2,
  output logic [DW-1:0]     data_out3,
  output logic [DW-1:0]     weight_out0,
  output logic [DW-1:0]     weight_out1,
  output logic [DW-1:0]     weight_out2,
  output logic [DW-1:0]     weight_out3,
  output logic [2*IW-1:0]   arr_out_sel,
  input  logic [RW-1:0]     arr_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RW-1:0]     res_data,
  output logic [2*IW-1:0]   res_idx,
  output logic              res_last
);

  localparam int unsigned SW = $clog2(FLUSH_CYCLES);

  state_e                  state_q;
  logic [SW-1:0]           step_q;
  logic [2*IW-1:0]         idx_q;
  logic [2*IW-1:0]         idx_nxt;
  logic                    load_ready_q, busy_q, done_q, arr_rst_q, arr_en_q;
  logic                    res_valid_q, res_last_q;
  logic [2*IW-1:0]         sel_q;
  logic [N-1:0][DW-1:0]    data_q, wgt_q;

  load_req_t               ld;
  logic                    wr_a, wr_b;
  logic [IW-1:0]           rd_k;
  logic [N-1:0][IW-1:0]    a_row, a_col, b_row, b_col;
  logic [N-1:0][DW-1:0]    a_rd, b_rd;

  // Row writes are only accepted while idle (load_ready_q is the idle flag).
  assign ld   = '{sel: load_sel, idx: load_idx, data: load_data};
  assign wr_a = load_valid && load_ready_q && !ld.sel;
  assign wr_b = load_valid && load_ready_q &&  ld.sel;

  // Outputs are registered one cycle ahead, so read the slice for the next beat.
  always_comb begin
    rd_k = '0;
    if (state_q == FEED) rd_k = IW'(step_q + 1'b1);
    for (int i = 0; i < int'(N); i++) begin
      a_row[i] = IW'(i);
      a_col[i] = rd_k;
      b_row[i] = rd_k;
      b_col[i] = IW'(i);
    end
  end

  mm_opnd_buf u_buf_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_a),
    .wr_row  (ld.idx),
    .wr_data (ld.data),
    .rd_row  (a_row),
    .rd_col  (a_col),
    .rd_data (a_rd)
  );

  mm_opnd_buf u_buf_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_b),
    .wr_row  (ld.idx),
    .wr_data (ld.data),
    .rd_row  (b_row),
    .rd_col  (b_col),
    .rd_data (b_rd)
  );

  assign idx_nxt = idx_q + 1'b1;

  // Job sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      step_q       <= '0;
      idx_q        <= '0;
      load_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      arr_rst_q    <= 1'b1;
      arr_en_q     <= 1'b0;
      data_q       <= '0;
      wgt_q        <= '0;
      sel_q        <= '0;
      res_valid_q  <= 1'b0;
      res_last_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      arr_rst_q <= 1'b1;
      data_q    <= '0;
      wgt_q     <= '0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= CLEAR;
            load_ready_q <= 1'b0;
            busy_q       <= 1'b1;
            arr_rst_q    <= 1'b0;
            idx_q        <= '0;
            sel_q        <= '0;
          end
        end
        CLEAR: begin
          state_q  <= FEED;
          step_q   <= '0;
          arr_en_q <= 1'b1;
          data_q   <= a_rd;
          wgt_q    <= b_rd;
        end
        FEED: begin
          if (step_q == SW'(FEED_LEN - 1)) begin
            state_q <= FLUSH;
            step_q  <= '0;
          end else begin
            step_q <= step_q + 1'b1;
            data_q <= a_rd;
            wgt_q  <= b_rd;
          end
        end
        FLUSH: begin
          if (step_q == SW'(FLUSH_CYCLES - 1)) begin
            state_q     <= DRAIN;
            step_q      <= '0;
            arr_en_q    <= 1'b0;
            res_valid_q <= 1'b1;
            res_last_q  <= 1'b0;
          end else begin
            step_q <= step_q + 1'b1;
          end
        end
        DRAIN: begin
          if (res_ready) begin
            if (idx_q == 4'(N*N - 1)) begin
              state_q      <= IDLE;
              res_valid_q  <= 1'b0;
              res_last_q   <= 1'b0;
              done_q       <= 1'b1;
              busy_q       <= 1'b0;
              load_ready_q <= 1'b1;
              idx_q        <= '0;
              sel_q        <= '0;
            end else begin
              idx_q      <= idx_nxt;
              sel_q      <= arr_sel_of(idx_nxt);
              res_last_q <= (idx_nxt == 4'(N*N - 1));
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Array reset follows the controller reset as well as the CLEAR pulse.
  assign arr_rst_n   = arr_rst_q & rst_n;
  assign load_ready  = load_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign arr_en      = arr_en_q;
  assign data_out0   = data_q[0];
  assign data_out1   = data_q[1];
  assign data_out2   = data_q[2];
  assign data_out3   = data_q[3];
  assign weight_out0 = wgt_q[0];
  assign weight_out1 = wgt_q[1];
  assign weight_out2 = wgt_q[2];
  assign weight_out3 = wgt_q[3];
  assign arr_out_sel = sel_q;
  assign res_valid   = res_valid_q;
  assign res_data    = arr_result;
  assign res_idx     = idx_q;
  assign res_last    = res_last_q;

endmodule
